// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// riscv_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the MEM-stage load/store unit: ALU opcodes that
// select a memory access, funct3 access-size encodings and the LSU FSM state
// type.
// Revision: 1.0  initial release
// ============================================================================
package riscv_pkg;

  // ALU opcodes that turn the ALU result into an effective address
  localparam logic [4:0] ALU_LOAD  = 5'b10100;
  localparam logic [4:0] ALU_STORE = 5'b10101;

  // funct3 access size / signedness
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // LSU control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align
// ----------------------------------------------------------------------------
// Purely combinational lane steering for the load/store unit.
//   Inputs : addr_lo    - byte offset within the word
//            funct3     - access size / signedness
//            is_store   - 1 for a store access
//            store_data - rs2 value to be written
//            rdata      - word returned by data memory
//   Outputs: be         - byte enables for the access
//            wdata      - store data moved into its byte lane(s)
//            fault      - illegal funct3 or misaligned address
//            load_data  - selected lane, sign/zero extended to 32 bits
// Revision: 1.0  initial release
// ============================================================================
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        fault,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] lane;
  logic        illegal_f3;
  logic        store_bad;
  logic        half_mis;
  logic        word_mis;

  // Byte offset expressed as a bit shift
  assign shamt = {addr_lo, 3'b000};

  always_comb begin
    be = 4'b1111;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
  end

  // Shifting left places the low byte/half into the lane selected by addr
  assign wdata = store_data << shamt;

  assign illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) ||
                      (funct3 == 3'b111);
  // Stores have no unsigned variants
  assign store_bad  = is_store & funct3[2];
  assign half_mis   = (funct3[1:0] == 2'b01) & addr_lo[0];
  assign word_mis   = (funct3[1:0] == 2'b10) & (addr_lo != 2'b00);
  assign fault      = illegal_f3 | store_bad | half_mis | word_mis;

  // Bring the addressed lane down to bit 0 before extension
  assign lane = rdata >> shamt;

  always_comb begin
    load_data = lane;
    case (funct3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_BU:   load_data = {24'h000000, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_HU:   load_data = {16'h0000, lane[15:0]};
      default: load_data = lane;
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu
// ----------------------------------------------------------------------------
// MEM pipeline stage: passes non-memory ALU results to writeback after one
// register stage, and runs load/store operations over a req/gnt/rvalid data
// memory port, holding off EX while a transaction is outstanding.
//   EX side  : ex_valid/ex_ready handshake, ex_alu_ctrl, ex_alu_result
//              (effective address for L/S), ex_store_data, ex_funct3,
//              ex_rd, ex_rd_we
//   Memory   : dmem_req/we/addr/be/wdata out, dmem_gnt/rvalid/rdata in
//   Writeback: wb_valid pulse with wb_we, wb_rd, wb_data, lsu_fault
// All dmem_* and wb_* outputs are registered; ex_ready decodes state only.
// Revision: 1.0  initial release
// ============================================================================
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [4:0]        ex_alu_ctrl,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_rd_we,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              lsu_fault
);

  lsu_state_t        state_q,      state_d;
  logic [1:0]        addr_lo_q,    addr_lo_d;
  logic [2:0]        funct3_q,     funct3_d;
  logic [4:0]        rd_q,         rd_d;
  logic              is_store_q,   is_store_d;

  logic              dmem_req_q,   dmem_req_d;
  logic              dmem_we_q,    dmem_we_d;
  logic [ADDR_W-1:0] dmem_addr_q,  dmem_addr_d;
  logic [3:0]        dmem_be_q,    dmem_be_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic              wb_valid_q,   wb_valid_d;
  logic              wb_we_q,      wb_we_d;
  logic [4:0]        wb_rd_q,      wb_rd_d;
  logic [31:0]       wb_data_q,    wb_data_d;
  logic              lsu_fault_q,  lsu_fault_d;

  logic [ADDR_W-1:0] ex_addr;
  logic              ex_is_load;
  logic              ex_is_store;
  logic [1:0]        al_addr_lo;
  logic [2:0]        al_funct3;
  logic              al_is_store;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              al_fault;
  logic [31:0]       al_load_data;

  assign ex_addr     = ex_alu_result[ADDR_W-1:0];
  assign ex_is_load  = (ex_alu_ctrl == ALU_LOAD);
  assign ex_is_store = (ex_alu_ctrl == ALU_STORE);

  // One aligner serves both phases: in IDLE it looks at the incoming EX
  // operation (be/wdata/fault), afterwards at the latched access (load data).
  always_comb begin
    al_addr_lo  = addr_lo_q;
    al_funct3   = funct3_q;
    al_is_store = is_store_q;
    if (state_q == ST_IDLE) begin
      al_addr_lo  = ex_addr[1:0];
      al_funct3   = ex_funct3;
      al_is_store = ex_is_store;
    end
  end

  lsu_align u_align (
    .addr_lo    (al_addr_lo),
    .funct3     (al_funct3),
    .is_store   (al_is_store),
    .store_data (ex_store_data),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .fault      (al_fault),
    .load_data  (al_load_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    is_store_d   = is_store_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    // Writeback strobes are single-cycle; the payload simply holds
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    lsu_fault_d  = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_is_load || ex_is_store) begin
            addr_lo_d  = ex_addr[1:0];
            funct3_d   = ex_funct3;
            rd_d       = ex_rd;
            is_store_d = ex_is_store;
            if (al_fault) begin
              // Report the fault straight away, memory is never touched
              wb_valid_d  = 1'b1;
              lsu_fault_d = 1'b1;
              wb_we_d     = 1'b0;
              wb_rd_d     = ex_rd;
            end else begin
              state_d      = ST_REQ;
              dmem_req_d   = 1'b1;
              dmem_we_d    = ex_is_store;
              dmem_addr_d  = {ex_addr[ADDR_W-1:2], 2'b00};
              dmem_be_d    = al_be;
              dmem_wdata_d = al_wdata;
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = ex_rd_we;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_result;
          end
        end
      end

      ST_REQ: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (is_store_q) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rd_d    = rd_q;
          end else if (dmem_rvalid) begin
            // Zero-latency memory: data returns with the grant
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            wb_we_d    = (rd_q != 5'd0);
            wb_rd_d    = rd_q;
            wb_data_d  = al_load_data;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (dmem_rvalid) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b1;
          wb_we_d    = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = al_load_data;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_lo_q    <= 2'b00;
      funct3_q     <= 3'b000;
      rd_q         <= 5'd0;
      is_store_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= 4'b0000;
      dmem_wdata_q <= 32'h0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'h0;
      lsu_fault_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      is_store_q   <= is_store_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      lsu_fault_q  <= lsu_fault_d;
    end
  end

  assign ex_ready   = (state_q == ST_IDLE);
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign lsu_fault  = lsu_fault_q;

endmodule : mem_stage_lsu
`default_nettype wire
